// File: rtl/fp_mult_seq_if.sv
// Operand/result bundle of the sequential FP multiplier.
// The master drives the request and operands; the slave returns the result and status.
interface fp_mult_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic         rnd_mode;
  logic [W-1:0] multiplicando;
  logic [W-1:0] multiplicador;
  logic [W-1:0] produto;
  logic         done;
  logic         busy;
  logic         overflow;
  logic         underflow;

  modport master (
    output start, rnd_mode, multiplicando, multiplicador,
    input  produto, done, busy, overflow, underflow
  );

  modport slave (
    input  start, rnd_mode, multiplicando, multiplicador,
    output produto, done, busy, overflow, underflow
  );
endinterface

// File: rtl/fp_mult_seq.sv
// Self-sequenced FP multiplier: shift-add significand product, normalise, round, special cases.
// Fixed latency of MAN_W+3 cycles from accept to done; start is ignored while busy.
module fp_mult_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic        clock,
  input  logic        reset,
  fp_mult_seq_if.slave bus
);
  localparam int N    = MAN_W + 1;
  localparam int EW   = EXP_W + 2;
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (2 ** (EXP_W - 1)) - 1;
  localparam int CW   = $clog2(N);
  localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);

  typedef enum logic [2:0] {IDLE, MULT, NORM, ROUND, DONE} state_t;

  state_t                 state_q;
  logic                   sign_q, trunc_q, nan_q, inf_q, zero_q;
  logic [EXP_W-1:0]       ea_q, eb_q;
  logic [N-1:0]           mcand_q, man_q;
  logic [2*N-1:0]         acc_q;
  logic [CW-1:0]          cnt_q;
  logic signed [EW-1:0]   exp_q;
  logic                   grd_q, rbit_q, stk_q;
  logic [W-1:0]           prod_q;
  logic                   done_q, busy_q, ovf_q, unf_q;

  logic [EXP_W-1:0]       ea_d, eb_d;
  logic [MAN_W-1:0]       ma_d, mb_d;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [N:0]             psum_d, rsum_d;
  logic [2*N-1:0]         norm_d;
  logic signed [EW-1:0]   enorm_d, efin_d;
  logic                   inc_d, ovf_d, unf_d, res_ovf_d, res_unf_d;
  logic [MAN_W-1:0]       mfin_d;
  logic [W-1:0]           res_d;

  always_comb begin
    ea_d   = bus.multiplicando[W-2 -: EXP_W];
    eb_d   = bus.multiplicador[W-2 -: EXP_W];
    ma_d   = bus.multiplicando[MAN_W-1:0];
    mb_d   = bus.multiplicador[MAN_W-1:0];
    a_zero = (ea_d == '0);
    b_zero = (eb_d == '0);
    a_inf  = (&ea_d) && (ma_d == '0);
    b_inf  = (&eb_d) && (mb_d == '0);
    a_nan  = (&ea_d) && (ma_d != '0);
    b_nan  = (&eb_d) && (mb_d != '0);
  end

  // Upper half of the accumulator gathers partial sums; the multiplier shifts out of the lower half.
  always_comb begin
    psum_d = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  end

  always_comb begin
    norm_d  = acc_q[2*N-1] ? acc_q : {acc_q[2*N-2:0], 1'b0};
    enorm_d = EW'(ea_q) + EW'(eb_q) - EW'(BIAS) + EW'(acc_q[2*N-1]);
  end

  always_comb begin
    inc_d  = ~trunc_q & grd_q & (rbit_q | stk_q | man_q[0]);
    rsum_d = {1'b0, man_q} + (N+1)'(inc_d);
    mfin_d = rsum_d[N] ? rsum_d[MAN_W:1] : rsum_d[MAN_W-1:0];
    efin_d = rsum_d[N] ? exp_q + EW'(1) : exp_q;
    ovf_d  = !efin_d[EW-1] && (efin_d >= EMAX);
    unf_d  = efin_d[EW-1] || (efin_d == '0);
  end

  always_comb begin
    res_d     = {sign_q, efin_d[EXP_W-1:0], mfin_d};
    res_ovf_d = 1'b0;
    res_unf_d = 1'b0;
    if (nan_q) begin
      res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (inf_q) begin
      res_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_q) begin
      res_d = {sign_q, {(W-1){1'b0}}};
    end else if (ovf_d) begin
      res_d     = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_ovf_d = 1'b1;
    end else if (unf_d) begin
      res_d     = {sign_q, {(W-1){1'b0}}};
      res_unf_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      trunc_q <= 1'b0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      zero_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      mcand_q <= '0;
      man_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      grd_q   <= 1'b0;
      rbit_q  <= 1'b0;
      stk_q   <= 1'b0;
      prod_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= MULT;
            busy_q  <= 1'b1;
            sign_q  <= bus.multiplicando[W-1] ^ bus.multiplicador[W-1];
            trunc_q <= bus.rnd_mode;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            mcand_q <= {1'b1, ma_d};
            acc_q   <= {{N{1'b0}}, 1'b1, mb_d};
            cnt_q   <= '0;
            nan_q   <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
            inf_q   <= a_inf | b_inf;
            zero_q  <= a_zero | b_zero;
          end
        end
        MULT: begin
          acc_q <= {psum_d, acc_q[N-1:1]};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_q <= NORM;
        end
        NORM: begin
          man_q   <= norm_d[2*N-1:N];
          grd_q   <= norm_d[N-1];
          rbit_q  <= norm_d[N-2];
          stk_q   <= |norm_d[N-3:0];
          exp_q   <= enorm_d;
          state_q <= ROUND;
        end
        ROUND: begin
          prod_q  <= res_d;
          ovf_q   <= res_ovf_d;
          unf_q   <= res_unf_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.produto   = prod_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_fp_mult_seq.sv
// Bench for fp_mult_seq: single- and half-precision instances against an arithmetic reference model.
module tb_fp_mult_seq;
  logic clock = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clock = ~clock;

  fp_mult_seq_if bus_s ();
  fp_mult_seq_if #(.EXP_W(5), .MAN_W(10)) bus_h ();

  fp_mult_seq dut_s (.clock(clock), .reset(reset), .bus(bus_s));
  fp_mult_seq #(.EXP_W(5), .MAN_W(10)) dut_h (.clock(clock), .reset(reset), .bus(bus_h));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, want);
  endtask

  // Reference: exact integer product of the significands, rounding by comparing the discarded part to one half.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit trunc,
                                          input int ew, input int mw, output bit ovf, output bit unf);
    longint one = 1;
    longint emaxf, bias, ea, eb, ma, mb, sgn, p, e, m, rem, half;
    int sh;
    emaxf = (one << ew) - 1;
    bias  = (one << (ew - 1)) - 1;
    ea    = (longint'(a) >> mw) & emaxf;
    eb    = (longint'(b) >> mw) & emaxf;
    ma    = longint'(a) & ((one << mw) - 1);
    mb    = longint'(b) & ((one << mw) - 1);
    sgn   = ((longint'(a) >> (ew + mw)) ^ (longint'(b) >> (ew + mw))) & 1;
    ovf   = 1'b0;
    unf   = 1'b0;
    if ((ea == emaxf && ma != 0) || (eb == emaxf && mb != 0) ||
        (ea == emaxf && eb == 0) || (ea == 0 && eb == emaxf))
      return 32'((emaxf << mw) | (one << (mw - 1)));
    if (ea == emaxf || eb == emaxf) return 32'((sgn << (ew + mw)) | (emaxf << mw));
    if (ea == 0 || eb == 0) return 32'(sgn << (ew + mw));
    p  = ((one << mw) | ma) * ((one << mw) | mb);
    e  = ea + eb - bias;
    sh = mw;
    if (p >= (one << (2 * mw + 1))) begin
      sh = mw + 1;
      e++;
    end
    m    = p >> sh;
    rem  = p - (m << sh);
    half = one << (sh - 1);
    if (!trunc && (rem > half || (rem == half && (m & 1) == 1))) m++;
    if (m == (one << (mw + 1))) begin
      m = m >> 1;
      e++;
    end
    if (e >= emaxf) begin
      ovf = 1'b1;
      return 32'((sgn << (ew + mw)) | (emaxf << mw));
    end
    if (e <= 0) begin
      unf = 1'b1;
      return 32'(sgn << (ew + mw));
    end
    return 32'((sgn << (ew + mw)) | (e << mw) | (m & ((one << mw) - 1)));
  endfunction

  task automatic drive(input bit half, input bit st, input logic [31:0] a, input logic [31:0] b, input bit trunc);
    if (half) begin
      bus_h.start = st; bus_h.multiplicando = a[15:0]; bus_h.multiplicador = b[15:0]; bus_h.rnd_mode = trunc;
    end else begin
      bus_s.start = st; bus_s.multiplicando = a; bus_s.multiplicador = b; bus_s.rnd_mode = trunc;
    end
  endtask

  function automatic logic [31:0] rd_prod(input bit half);
    return half ? {16'h0, bus_h.produto} : bus_s.produto;
  endfunction

  // {done, busy, overflow, underflow}
  function automatic logic [3:0] rd_flags(input bit half);
    return half ? {bus_h.done, bus_h.busy, bus_h.overflow, bus_h.underflow}
                : {bus_s.done, bus_s.busy, bus_s.overflow, bus_s.underflow};
  endfunction

  task automatic run_op(input string tag, input bit half, input logic [31:0] a, input logic [31:0] b,
                        input bit trunc, input bit disturb);
    logic [31:0] want;
    logic [3:0]  f;
    bit          eo, eu;
    int          lat, mw;
    mw   = half ? 10 : 23;
    want = ref_mul(a, b, trunc, half ? 5 : 8, mw, eo, eu);
    @(negedge clock); drive(half, 1'b1, a, b, trunc);
    @(negedge clock); drive(half, 1'b0, a, b, trunc);
    f = rd_flags(half);
    chk({tag, "_busy_up"}, 32'(f[2]), 32'd1);
    lat = 0;
    while (!f[3] && lat < 60) begin
      @(negedge clock);
      lat++;
      if (disturb) begin
        if (lat < 15) drive(half, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
        else drive(half, 1'b0, a, b, trunc);
      end
      f = rd_flags(half);
    end
    chk({tag, "_lat"}, 32'(lat), 32'(mw + 3));
    chk({tag, "_prod"}, rd_prod(half), want);
    chk({tag, "_ovf"}, 32'(f[1]), 32'(eo));
    chk({tag, "_unf"}, 32'(f[0]), 32'(eu));
    @(negedge clock);
    f = rd_flags(half);
    chk({tag, "_done_pulse"}, 32'(f[3]), 32'd0);
    chk({tag, "_busy_down"}, 32'(f[2]), 32'd0);
    chk({tag, "_hold"}, rd_prod(half), want);
  endtask

  initial begin
    logic [31:0] a, b, want;
    logic [3:0]  f;
    bit          eo, eu;
    int          ndone, d1, d2;

    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clock);
    chk("rst_prod", rd_prod(1'b0), 32'h0);
    chk("rst_flags", 32'(rd_flags(1'b0)), 32'h0);
    reset = 1'b0;

    run_op("sq15", 1'b0, 32'h3FC00000, 32'h3FC00000, 1'b0, 1'b0);
    run_op("neg_dist", 1'b0, 32'hBFC00000, 32'h40000000, 1'b0, 1'b1);
    run_op("rne", 1'b0, 32'h3FC00001, 32'h3FC00001, 1'b0, 1'b0);
    run_op("trunc", 1'b0, 32'h3FC00001, 32'h3FC00001, 1'b1, 1'b0);
    run_op("ovf", 1'b0, 32'h7F000000, 32'h40000000, 1'b0, 1'b0);
    run_op("unf", 1'b0, 32'h00800000, 32'h00800000, 1'b0, 1'b0);
    run_op("inf_x_0", 1'b0, 32'h7F800000, 32'h00000000, 1'b0, 1'b0);
    run_op("ninf_x_1", 1'b0, 32'hFF800000, 32'h3F800000, 1'b0, 1'b0);
    run_op("nan", 1'b0, 32'h7F812345, 32'h3F800000, 1'b0, 1'b0);
    run_op("half_sq15", 1'b1, 32'h3E00, 32'h3E00, 1'b0, 1'b0);

    // Abort at MULT cycle 10: produto currently holds a nonzero result, so the clear is visible.
    run_op("pre_abort", 1'b0, 32'h40400000, 32'h40400000, 1'b0, 1'b0);
    @(negedge clock); drive(1'b0, 1'b1, 32'h3FC00000, 32'h40000000, 1'b0);
    @(negedge clock); drive(1'b0, 1'b0, 32'h3FC00000, 32'h40000000, 1'b0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_prod", rd_prod(1'b0), 32'h0);
    chk("abort_flags", 32'(rd_flags(1'b0)), 32'h0);
    ndone = 0;
    repeat (30) begin
      @(negedge clock);
      f = rd_flags(1'b0);
      if (f[3]) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op("post_abort", 1'b0, 32'h3FC00000, 32'h40000000, 1'b0, 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clock); reset = 1'b1; drive(1'b0, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0);
    @(negedge clock); reset = 1'b0; drive(1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 1'b0);
    f = rd_flags(1'b0);
    chk("rst_vs_start_busy", 32'(f[2]), 32'd0);

    // Start held high: back-to-back operations MAN_W+5 cycles apart.
    want = ref_mul(32'h40A00000, 32'h3FC00000, 1'b0, 8, 23, eo, eu);
    @(negedge clock); drive(1'b0, 1'b1, 32'h40A00000, 32'h3FC00000, 1'b0);
    d1 = -1; d2 = -1;
    for (int c = 0; c < 100 && d2 < 0; c++) begin
      @(negedge clock);
      f = rd_flags(1'b0);
      if (f[3]) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
    end
    drive(1'b0, 1'b0, 32'h40A00000, 32'h3FC00000, 1'b0);
    chk("held_spacing", 32'(d2 - d1), 32'd28);
    chk("held_prod", rd_prod(1'b0), want);
    repeat (2) @(negedge clock);
    f = rd_flags(1'b0);
    chk("held_idle", 32'(f[2]), 32'd0);

    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      a[30:23] = 8'($urandom_range(40, 215));
      b[30:23] = 8'($urandom_range(40, 215));
      run_op($sformatf("rnd_s%0d", i), 1'b0, a, b, 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("rnd_h%0d", i), 1'b1, {16'h0, 16'($urandom)}, {16'h0, 16'($urandom)},
             1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
